// File: rtl/deadtime_pkg.sv
// Shared types and defaults for the complementary dead-time gate driver.
package deadtime_pkg;

   localparam int unsigned NCH_DEF         = 16;
   localparam int unsigned DT_W_DEF        = 8;
   localparam int unsigned SYNC_STAGES_DEF = 2;

   typedef enum logic [2:0] {
      OFF,
      DT_TO_HI,
      HI,
      DT_TO_LO,
      LO
   } ch_state_t;

   function automatic logic is_dt(input ch_state_t s);
      return (s == DT_TO_HI) || (s == DT_TO_LO);
   endfunction

endpackage

// File: rtl/deadtime_ch.sv
// One complementary channel: commutation FSM, dead-time counter and registered gate drives.
module deadtime_ch
   import deadtime_pkg::*;
#(
   parameter int unsigned DT_W = DT_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   input  logic            pwm_s,
   input  logic [DT_W-1:0] dt_cycles,
   output logic            hi,
   output logic            lo,
   output logic            busy
);

   ch_state_t       state_q, state_d;
   logic [DT_W-1:0] cnt_q, cnt_d;
   logic            hi_q, hi_d;
   logic            lo_q, lo_d;
   logic            busy_q, busy_d;
   logic            cnt_done_c;

   // A loaded count of 0 or 1 both expire after a single dead cycle.
   assign cnt_done_c = (cnt_q <= DT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OFF;
         cnt_q   <= '0;
         hi_q    <= 1'b0;
         lo_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!run) begin
         state_d = OFF;
         cnt_d   = '0;
      end else begin
         case (state_q)
            OFF: begin
               state_d = pwm_s ? DT_TO_HI : DT_TO_LO;
               cnt_d   = dt_cycles;
            end
            DT_TO_HI: begin
               if (!pwm_s) begin
                  state_d = DT_TO_LO;
                  cnt_d   = dt_cycles;
               end else if (cnt_done_c) begin
                  state_d = HI;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DT_W'(1);
               end
            end
            DT_TO_LO: begin
               if (pwm_s) begin
                  state_d = DT_TO_HI;
                  cnt_d   = dt_cycles;
               end else if (cnt_done_c) begin
                  state_d = LO;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - DT_W'(1);
               end
            end
            HI: begin
               if (!pwm_s) begin
                  state_d = DT_TO_LO;
                  cnt_d   = dt_cycles;
               end
            end
            LO: begin
               if (pwm_s) begin
                  state_d = DT_TO_HI;
                  cnt_d   = dt_cycles;
               end
            end
            default: begin
               state_d = OFF;
               cnt_d   = '0;
            end
         endcase
      end
      // Drives follow the next state so they change on the same edge as the FSM.
      hi_d   = (state_d == HI);
      lo_d   = (state_d == LO);
      busy_d = is_dt(state_d);
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;

endmodule

// File: rtl/deadtime_gen.sv
// N-channel complementary gate driver: input synchronisers, sticky fault latch and per-channel dead-time FSMs.
module deadtime_gen
   import deadtime_pkg::*;
#(
   parameter int unsigned NCH         = NCH_DEF,
   parameter int unsigned DT_W        = DT_W_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [DT_W-1:0] dt_cycles,
   input  logic [NCH-1:0]  pwm_in,
   input  logic            fault_in,
   input  logic            fault_clr,
   output logic [NCH-1:0]  hi_out,
   output logic [NCH-1:0]  lo_out,
   output logic [NCH-1:0]  busy,
   output logic            fault_latched
);

   logic [SYNC_STAGES-1:0][NCH-1:0] pwm_sync_q;
   logic [SYNC_STAGES-1:0]          fault_sync_q;
   logic [NCH-1:0]                  pwm_s_c;
   logic                            fault_s_c;
   logic                            fault_latched_q, fault_latched_d;
   logic                            run_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_sync_q      <= '0;
         fault_sync_q    <= '0;
         fault_latched_q <= 1'b0;
      end else begin
         pwm_sync_q      <= {pwm_sync_q[SYNC_STAGES-2:0], pwm_in};
         fault_sync_q    <= {fault_sync_q[SYNC_STAGES-2:0], fault_in};
         fault_latched_q <= fault_latched_d;
      end
   end

   assign pwm_s_c   = pwm_sync_q[SYNC_STAGES-1];
   assign fault_s_c = fault_sync_q[SYNC_STAGES-1];

   // Set dominates clear, so a clear pulse while the fault persists is ignored.
   assign fault_latched_d = fault_s_c | (fault_latched_q & ~fault_clr);

   // Gating on the latch's next value makes shutdown land on the same edge the latch sets.
   assign run_c = en & ~fault_latched_d;

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_ch
         deadtime_ch #(
            .DT_W (DT_W)
         ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .run       (run_c),
            .pwm_s     (pwm_s_c[g]),
            .dt_cycles (dt_cycles),
            .hi        (hi_out[g]),
            .lo        (lo_out[g]),
            .busy      (busy[g])
         );
      end
   endgenerate

   assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_deadtime_gen.sv
// Directed scoreboard bench for deadtime_gen followed by a randomised overlap/dead-time sweep.
module tb_deadtime_gen;

   localparam int unsigned NCH  = 16;
   localparam int unsigned DT_W = 8;

   localparam int K_CH    = 0;
   localparam int K_ALL   = 1;
   localparam int K_FAULT = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic [DT_W-1:0] dt_cycles;
   logic [NCH-1:0]  pwm_in;
   logic            fault_in;
   logic            fault_clr;
   logic [NCH-1:0]  hi_out;
   logic [NCH-1:0]  lo_out;
   logic [NCH-1:0]  busy;
   logic            fault_latched;

   typedef struct {
      int    at;
      int    kind;
      int    ch;
      logic  h;
      logic  l;
      logic  b;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   logic [NCH-1:0] prev_hi   = '0;
   logic [NCH-1:0] prev_lo   = '0;
   logic [NCH-1:0] prev_busy = '0;

   always #5 clk = ~clk;

   deadtime_gen #(
      .NCH         (NCH),
      .DT_W        (DT_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .dt_cycles     (dt_cycles),
      .pwm_in        (pwm_in),
      .fault_in      (fault_in),
      .fault_clr     (fault_clr),
      .hi_out        (hi_out),
      .lo_out        (lo_out),
      .busy          (busy),
      .fault_latched (fault_latched)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push(input int rel, input int kind, input int ch,
                       input logic h, input logic l, input logic b, input string tag);
      exp_t e;
      e.at   = cyc + rel;
      e.kind = kind;
      e.ch   = ch;
      e.h    = h;
      e.l    = l;
      e.b    = b;
      e.tag  = tag;
      sb.push_back(e);
   endtask

   // Compare scoreboard entries due this cycle, then the always-on safety properties.
   task automatic check_due();
      int i;
      logic [NCH-1:0] rise;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].at == cyc) begin
            exp_t  e;
            string t;
            e = sb[i];
            t = $sformatf("%s@%0d", e.tag, cyc);
            if (e.kind == K_CH)
               chk(t, 32'({hi_out[e.ch], lo_out[e.ch], busy[e.ch]}), 32'({e.h, e.l, e.b}));
            else if (e.kind == K_ALL)
               chk(t, 32'({|hi_out, |lo_out, |busy}), 32'({e.h, e.l, e.b}));
            else
               chk(t, 32'(fault_latched), 32'(e.h));
            sb.delete(i);
         end else begin
            i++;
         end
      end
      chk($sformatf("no_overlap@%0d", cyc), 32'(hi_out & lo_out), 32'd0);
      rise = (hi_out & ~prev_hi) | (lo_out & ~prev_lo);
      chk($sformatf("dt_before_on@%0d", cyc), 32'(rise & ~prev_busy), 32'd0);
      prev_hi   = hi_out;
      prev_lo   = lo_out;
      prev_busy = busy;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         check_due();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      dt_cycles = '0;
      pwm_in    = '0;
      fault_in  = 1'b0;
      fault_clr = 1'b0;
      tick(2);
      chk("reset_outs", 32'({|hi_out, |lo_out, |busy}), 32'd0);
      chk("reset_fault", 32'(fault_latched), 32'd0);

      // Release reset with en low: everything stays off.
      rst_n = 1'b1;
      push(2, K_ALL, 0, 1'b0, 1'b0, 1'b0, "idle_after_reset");
      tick(3);

      // Enable with pwm[0]=1, dt=25; dt change mid-count must not matter.
      en        = 1'b1;
      dt_cycles = 8'd25;
      pwm_in[0] = 1'b1;
      push(1,  K_CH, 0, 1'b0, 1'b0, 1'b1, "start_dt_ch0");
      push(27, K_CH, 0, 1'b0, 1'b0, 1'b1, "start_dt_end_ch0");
      push(28, K_CH, 0, 1'b1, 1'b0, 1'b0, "start_hi_ch0");
      push(25, K_CH, 1, 1'b0, 1'b0, 1'b1, "start_dt_end_ch1");
      push(26, K_CH, 1, 1'b0, 1'b1, 1'b0, "start_lo_ch1");
      tick(10);
      dt_cycles = 8'd3;
      tick(10);
      dt_cycles = 8'd25;
      tick(10);

      // Commutate ch0 high -> low with dt=25.
      pwm_in[0] = 1'b0;
      push(2,  K_CH, 0, 1'b1, 1'b0, 1'b0, "hl_still_hi");
      push(3,  K_CH, 0, 1'b0, 1'b0, 1'b1, "hl_hi_fall");
      push(27, K_CH, 0, 1'b0, 1'b0, 1'b1, "hl_dt_end");
      push(28, K_CH, 0, 1'b0, 1'b1, 1'b0, "hl_lo_rise");
      tick(30);

      // dt=0 on ch5: exactly one dead cycle; then dt=1 behaves the same.
      dt_cycles = 8'd0;
      pwm_in[5] = 1'b1;
      push(2, K_CH, 5, 1'b0, 1'b1, 1'b0, "dt0_lo_before");
      push(3, K_CH, 5, 1'b0, 1'b0, 1'b1, "dt0_dead");
      push(4, K_CH, 5, 1'b1, 1'b0, 1'b0, "dt0_hi");
      tick(6);
      dt_cycles = 8'd1;
      pwm_in[5] = 1'b0;
      push(3, K_CH, 5, 1'b0, 1'b0, 1'b1, "dt1_dead");
      push(4, K_CH, 5, 1'b0, 1'b1, 1'b0, "dt1_lo");
      tick(6);

      // 10-cycle glitch shorter than dt=25: no high side, counter reloads on return.
      dt_cycles = 8'd25;
      pwm_in[0] = 1'b1;
      push(2,  K_CH, 0, 1'b0, 1'b1, 1'b0, "gl_lo_before");
      push(3,  K_CH, 0, 1'b0, 1'b0, 1'b1, "gl_dt_hi");
      push(12, K_CH, 0, 1'b0, 1'b0, 1'b1, "gl_dt_hi_end");
      push(13, K_CH, 0, 1'b0, 1'b0, 1'b1, "gl_dt_lo");
      push(28, K_CH, 0, 1'b0, 1'b0, 1'b1, "gl_no_early_exit");
      push(37, K_CH, 0, 1'b0, 1'b0, 1'b1, "gl_reload_end");
      push(38, K_CH, 0, 1'b0, 1'b1, 1'b0, "gl_lo_back");
      tick(10);
      pwm_in[0] = 1'b0;
      tick(30);

      // Bring ch0 to HI, then fault mid-HI.
      pwm_in[0] = 1'b1;
      push(28, K_CH, 0, 1'b1, 1'b0, 1'b0, "pre_fault_hi");
      tick(30);
      fault_in = 1'b1;
      push(2, K_CH,    0, 1'b1, 1'b0, 1'b0, "fault_hi_held");
      push(2, K_FAULT, 0, 1'b0, 1'b0, 1'b0, "fault_not_yet");
      push(3, K_ALL,   0, 1'b0, 1'b0, 1'b0, "fault_all_off");
      push(3, K_FAULT, 0, 1'b1, 1'b0, 1'b0, "fault_set");
      tick(5);
      fault_clr = 1'b1;
      push(1, K_FAULT, 0, 1'b1, 1'b0, 1'b0, "clr_while_fault");
      push(3, K_FAULT, 0, 1'b1, 1'b0, 1'b0, "clr_while_fault_2");
      tick(1);
      fault_clr = 1'b0;
      tick(4);
      fault_in = 1'b0;
      push(4, K_FAULT, 0, 1'b1, 1'b0, 1'b0, "fault_sticky");
      push(4, K_ALL,   0, 1'b0, 1'b0, 1'b0, "fault_still_off");
      tick(5);
      fault_clr = 1'b1;
      push(1,  K_FAULT, 0, 1'b0, 1'b0, 1'b0, "fault_cleared");
      push(1,  K_CH,    0, 1'b0, 1'b0, 1'b1, "restart_dt_ch0");
      push(25, K_CH,    0, 1'b0, 1'b0, 1'b1, "restart_dt_end");
      push(26, K_CH,    0, 1'b1, 1'b0, 1'b0, "restart_hi_ch0");
      push(26, K_CH,    1, 1'b0, 1'b1, 1'b0, "restart_lo_ch1");
      tick(1);
      fault_clr = 1'b0;
      tick(29);

      // Global disable forces OFF next edge; re-enable restarts through dead time.
      en = 1'b0;
      push(1, K_ALL, 0, 1'b0, 1'b0, 1'b0, "disable_off");
      tick(3);
      en = 1'b1;
      push(1,  K_CH, 0, 1'b0, 1'b0, 1'b1, "reen_dt");
      push(25, K_CH, 0, 1'b0, 1'b0, 1'b1, "reen_dt_end");
      push(26, K_CH, 0, 1'b1, 1'b0, 1'b0, "reen_hi");
      tick(30);

      // Random sweep; overlap and dead-time-before-conduction are checked every cycle.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0)
            pwm_in = pwm_in ^ (NCH'($urandom) & NCH'($urandom));
         if ($urandom_range(0, 15) == 0)
            en = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 31) == 0)
            dt_cycles = DT_W'($urandom_range(0, 6));
         rst_n = ($urandom_range(0, 199) != 0);
         tick(1);
      end
      rst_n = 1'b1;
      en    = 1'b0;
      tick(2);
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
